unary_stream_gen: RTL and testbench

Upstream stimulus stage for the serial unary adder. Takes two binary operands and a start pulse, and emits two serial unary bitstreams (A, B) framed by en. It then switches the adder to output mode (read_or_write=1) for a drain window and reports completion. Its outputs connect directly to the adder's A, B, en and read_or_write inputs.

---
 rtl/unary_pkg.sv | 20 ++
 rtl/unary_stream_gen.sv | 122 ++++++++++++
 tb/tb_unary_stream_gen.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/unary_pkg.sv
// rtl/unary_pkg.sv - shared types and helpers for the unary stream generator
package unary_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  function automatic int stream_len(input int width);
    return (1 << width) - 1;
  endfunction

  // Reverses the low `width` bits of v; bits at and above `width` come back zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = v[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/unary_stream_gen.sv
// rtl/unary_stream_gen.sv - serial unary stimulus generator for the unary adder
// Optional UNARY_STREAM_GEN_SHUFFLE_EN: bit-reversed emission order instead of thermometer.
module unary_stream_gen #(
  parameter int WIDTH        = 4,
  parameter int DRAIN_CYCLES = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_val,
  input  logic [WIDTH-1:0] b_val,
  output logic             A,
  output logic             B,
  output logic             en,
  output logic             read_or_write,
  output logic             busy,
  output logic             done
);
  import unary_pkg::*;

  localparam int LEN     = stream_len(WIDTH);
  localparam int CNT_MAX = (LEN > DRAIN_CYCLES) ? LEN : DRAIN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STREAM_LAST = CW'(LEN - 1);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] idx;
  logic             stream_a_q, stream_a_d, stream_b_q, stream_b_d;
  logic             en_q, en_d, rw_q, rw_d, busy_q, busy_d, done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      stream_a_q <= 1'b0;
      stream_b_q <= 1'b0;
      en_q       <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      stream_a_q <= stream_a_d;
      stream_b_q <= stream_b_d;
      en_q       <= en_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          cnt_d   = '0;
          a_d     = a_val;
          b_d     = b_val;
        end
      end
      STREAM: begin
        if (cnt_q == STREAM_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef UNARY_STREAM_GEN_SHUFFLE_EN
    idx = WIDTH'(bit_rev(32'(cnt_d), WIDTH));
`else
    idx = cnt_d[WIDTH-1:0];
`endif

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    stream_a_d = (state_d == STREAM) && (idx < a_d);
    stream_b_d = (state_d == STREAM) && (idx < b_d);
    en_d       = (state_d == STREAM) || (state_d == DRAIN);
    rw_d       = (state_d == DRAIN);
    busy_d     = (state_d == STREAM) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  assign A             = stream_a_q;
  assign B             = stream_b_q;
  assign en            = en_q;
  assign read_or_write = rw_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_unary_stream_gen.sv
// tb/tb_unary_stream_gen.sv - directed self-checking bench for unary_stream_gen
module tb_unary_stream_gen;

  localparam int LEN   = 15;
  localparam int DR    = 20;
  localparam int NOREP = 1000;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a_val;
  logic [3:0] b_val;
  logic       A, B, en, read_or_write, busy, done;

  int checks;
  int failures;
  logic [79:0] cap [6];

  unary_stream_gen #(.WIDTH(4), .DRAIN_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_val(a_val), .b_val(b_val),
    .A(A), .B(B), .en(en), .read_or_write(read_or_write), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int exp_idx(input int k);
    logic [3:0] v;
    v = k[3:0];
`ifdef UNARY_STREAM_GEN_SHUFFLE_EN
    return int'({v[0], v[1], v[2], v[3]});
`else
    return int'(v);
`endif
  endfunction

  // Expected waveform per field, index i = cycle i+1 after start was sampled.
  function automatic logic [79:0] exp_vec(input int f, input int a, input int b, input int n, input int period);
    logic [79:0] r;
    int p;
    r = '0;
    for (int i = 0; i < n; i++) begin
      p = i % period;
      case (f)
        0: r[i] = (p < LEN) && (exp_idx(p) < a);
        1: r[i] = (p < LEN) && (exp_idx(p) < b);
        2: r[i] = (p < LEN + DR);
        3: r[i] = (p >= LEN) && (p < LEN + DR);
        4: r[i] = (p < LEN + DR);
        default: r[i] = (p == LEN + DR);
      endcase
    end
    return r;
  endfunction

  function automatic string fname(input int f);
    case (f)
      0: return "A";
      1: return "B";
      2: return "en";
      3: return "read_or_write";
      4: return "busy";
      default: return "done";
    endcase
  endfunction

  function automatic int ones(input logic [79:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 80; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a_val = '0;
    b_val = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Records n cycles; start is assumed set by the caller at the preceding negedge.
  task automatic capture(input int n, input int p2, input bit hold);
    for (int f = 0; f < 6; f++) cap[f] = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap[0][i] = A;
      cap[1][i] = B;
      cap[2][i] = en;
      cap[3][i] = read_or_write;
      cap[4][i] = busy;
      cap[5][i] = done;
      if (!hold && i == 0) start = 1'b0;
      if (i == p2) begin
        start = 1'b1;
        a_val = 4'd1;
        b_val = 4'd1;
      end
      if (p2 >= 0 && i == p2 + 1) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a_val = '0;
    b_val = '0;
    #1;
    checks++;
    if ({A, B, en, read_or_write, busy, done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000", {A, B, en, read_or_write, busy, done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({A, B, en, read_or_write, busy, done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=000000", {A, B, en, read_or_write, busy, done});
    end
  endtask

  task automatic test_thermometer();
    apply_reset();
    start = 1'b1; a_val = 4'd3; b_val = 4'd0;
    capture(37, -1, 1'b0);
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (cap[f] !== exp_vec(f, 3, 0, 37, NOREP)) begin
        failures++;
        $display("FAIL thermo_%s got=%h exp=%h", fname(f), cap[f], exp_vec(f, 3, 0, 37, NOREP));
      end
    end
    checks++;
    if (ones(cap[0]) != 3) begin
      failures++;
      $display("FAIL thermo_a_ones got=%0d exp=3", ones(cap[0]));
    end
  endtask

  task automatic test_full();
    apply_reset();
    start = 1'b1; a_val = 4'd15; b_val = 4'd15;
    capture(37, -1, 1'b0);
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (cap[f] !== exp_vec(f, 15, 15, 37, NOREP)) begin
        failures++;
        $display("FAIL full_%s got=%h exp=%h", fname(f), cap[f], exp_vec(f, 15, 15, 37, NOREP));
      end
    end
    checks++;
    if (ones(cap[0]) + ones(cap[1]) != 30) begin
      failures++;
      $display("FAIL full_total got=%0d exp=30", ones(cap[0]) + ones(cap[1]));
    end
  endtask

  task automatic test_start_ignored();
    apply_reset();
    start = 1'b1; a_val = 4'd2; b_val = 4'd1;
    capture(60, 5, 1'b0);
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (cap[f] !== exp_vec(f, 2, 1, 60, NOREP)) begin
        failures++;
        $display("FAIL ignored_%s got=%h exp=%h", fname(f), cap[f], exp_vec(f, 2, 1, 60, NOREP));
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    start = 1'b1; a_val = 4'd15; b_val = 4'd15;
    capture(7, -1, 1'b0);
    checks++;
    if (cap[0][6] !== 1'b1 || cap[2][6] !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre got=%b%b exp=11", cap[0][6], cap[2][6]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({A, B, en, read_or_write, busy, done} !== 6'b0) begin
      failures++;
      $display("FAIL abort_async got=%b exp=000000", {A, B, en, read_or_write, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({A, B, en, read_or_write, busy, done} !== 6'b0) begin
      failures++;
      $display("FAIL abort_idle got=%b exp=000000", {A, B, en, read_or_write, busy, done});
    end
    start = 1'b1; a_val = 4'd3; b_val = 4'd0;
    capture(37, -1, 1'b0);
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (cap[f] !== exp_vec(f, 3, 0, 37, NOREP)) begin
        failures++;
        $display("FAIL abort_restart_%s got=%h exp=%h", fname(f), cap[f], exp_vec(f, 3, 0, 37, NOREP));
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    start = 1'b1; a_val = 4'd5; b_val = 4'd0;
    capture(80, -1, 1'b1);
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (cap[f] !== exp_vec(f, 5, 0, 80, LEN + DR + 2)) begin
        failures++;
        $display("FAIL b2b_%s got=%h exp=%h", fname(f), cap[f], exp_vec(f, 5, 0, 80, LEN + DR + 2));
      end
    end
  endtask

  task automatic test_order();
    apply_reset();
    start = 1'b1; a_val = 4'd4; b_val = 4'd2;
    capture(37, -1, 1'b0);
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (cap[f] !== exp_vec(f, 4, 2, 37, NOREP)) begin
        failures++;
        $display("FAIL order_%s got=%h exp=%h", fname(f), cap[f], exp_vec(f, 4, 2, 37, NOREP));
      end
    end
    checks++;
    if (ones(cap[0]) != 4 || ones(cap[1]) != 2) begin
      failures++;
      $display("FAIL order_ones got=%0d/%0d exp=4/2", ones(cap[0]), ones(cap[1]));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a_val    = '0;
    b_val    = '0;
    test_reset();
    test_thermometer();
    test_full();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    test_order();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
